// File: rtl/instr_prefetch_queue.sv
// Fetch-side prefetch FIFO: owns the fetch PC, buffers {pc, instr} pairs and
// presents them downstream with valid/ready; a taken jump flushes and redirects.
module instr_prefetch_queue #(
    parameter int PC_BITS    = 9,
    parameter int INSTR_BITS = 9,
    parameter int DEPTH      = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    fetch_en,
    output logic [PC_BITS-1:0]      fetch_pc,
    input  logic [INSTR_BITS-1:0]   instr_in,
    input  logic                    jump_flag,
    input  logic [PC_BITS-1:0]      jump_target,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INSTR_BITS-1:0]   out_instr,
    output logic [PC_BITS-1:0]      out_pc,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = PC_BITS + INSTR_BITS;

    logic [PC_BITS-1:0] fetch_pc_reg, fetch_pc_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [ENTRY_W-1:0] entry_reg [DEPTH];
    logic [ENTRY_W-1:0] head_entry;

    logic flush, push, pop, not_empty, not_full;

    assign not_empty = (count_reg != '0);
    assign not_full  = (count_reg != CNT_W'(DEPTH));
    assign flush     = jump_flag;
    // Full blocks the push even if a pop frees a slot in the same cycle.
    assign push      = fetch_en && not_full && !flush;
    assign pop       = not_empty && out_ready && !flush;

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        count_next    = count_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        if (flush) begin
            fetch_pc_next = jump_target;
            count_next    = '0;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
        end else begin
            if (push) begin
                fetch_pc_next = fetch_pc_reg + 1'b1;
                wr_ptr_next   = wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_next = count_reg + 1'b1;
            end else if (pop && !push) begin
                count_next = count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_reg <= '0;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            count_reg    <= count_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
        end
    end

    // Storage is never cleared; validity is tracked purely by count_reg.
    always_ff @(posedge clock) begin
        if (push) begin
            entry_reg[wr_ptr_reg] <= {fetch_pc_reg, instr_in};
        end
    end

    assign head_entry = entry_reg[rd_ptr_reg];

    assign fetch_pc  = fetch_pc_reg;
    assign count     = count_reg;
    assign out_valid = not_empty;
    assign out_pc    = not_empty ? head_entry[ENTRY_W-1:INSTR_BITS] : '0;
    assign out_instr = not_empty ? head_entry[INSTR_BITS-1:0] : '0;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Randomized and directed stimulus for instr_prefetch_queue, checked against a
// queue-based reference model of fetch/push/pop/flush behaviour.
module tb_instr_prefetch_queue;

    localparam int PC_BITS    = 9;
    localparam int INSTR_BITS = 9;
    localparam int DEPTH      = 4;

    typedef struct packed {
        logic [PC_BITS-1:0]    pc;
        logic [INSTR_BITS-1:0] instr;
    } ent_t;

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    logic                    fetch_en = 1'b0;
    logic [PC_BITS-1:0]      fetch_pc;
    logic [INSTR_BITS-1:0]   instr_in;
    logic                    jump_flag = 1'b0;
    logic [PC_BITS-1:0]      jump_target = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [INSTR_BITS-1:0]   out_instr;
    logic [PC_BITS-1:0]      out_pc;
    logic [$clog2(DEPTH):0]  count;

    logic [INSTR_BITS-1:0] imem [1 << PC_BITS];
    assign instr_in = imem[fetch_pc];

    ent_t               mq[$];
    logic [PC_BITS-1:0] m_pc;
    int                 checks = 0;
    int                 errors = 0;

    always #5 clock = ~clock;

    instr_prefetch_queue #(
        .PC_BITS(PC_BITS), .INSTR_BITS(INSTR_BITS), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .fetch_en(fetch_en), .fetch_pc(fetch_pc),
        .instr_in(instr_in), .jump_flag(jump_flag), .jump_target(jump_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .count(count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input string ctx);
        ent_t head;
        head = (mq.size() != 0) ? mq[0] : '0;
        check_val({ctx, ".count"}, 32'(count), 32'(mq.size()));
        check_val({ctx, ".fetch_pc"}, 32'(fetch_pc), 32'(m_pc));
        check_val({ctx, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
        check_val({ctx, ".out_pc"}, 32'(out_pc), 32'(head.pc));
        check_val({ctx, ".out_instr"}, 32'(out_instr), 32'(head.instr));
        $display("%s: fe=%0b jf=%0b rdy=%0b -> count=%0d fetch_pc=%03h valid=%0b out_pc=%03h",
                 ctx, fetch_en, jump_flag, out_ready, count, fetch_pc, out_valid, out_pc);
    endtask

    // Apply inputs, take one rising edge, advance the model, then compare.
    task automatic step(input string ctx, input logic fe, input logic jf,
                        input logic [PC_BITS-1:0] jt, input logic rdy);
        bit do_push, do_pop;
        fetch_en    = fe;
        jump_flag   = jf;
        jump_target = jt;
        out_ready   = rdy;
        @(posedge clock);
        if (jf) begin
            mq.delete();
            m_pc = jt;
        end else begin
            do_pop  = (mq.size() != 0) && rdy;
            do_push = fe && (mq.size() < DEPTH);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back('{pc: m_pc, instr: imem[m_pc]});
                m_pc = m_pc + 1'b1;
            end
        end
        #1;
        check_state(ctx);
    endtask

    initial begin
        for (int i = 0; i < (1 << PC_BITS); i++) imem[i] = INSTR_BITS'($urandom);
        mq.delete();
        m_pc = '0;
        #7;
        check_state("reset");
        @(negedge clock);
        reset = 1'b1;

        // Fill to full with no consumer, then one extra edge while full.
        for (int i = 0; i < 5; i++) step("fill", 1'b1, 1'b0, '0, 1'b0);
        step("pop_full", 1'b1, 1'b0, '0, 1'b1);
        step("refill", 1'b1, 1'b0, '0, 1'b0);

        // Streaming from an empty queue.
        step("jump0", 1'b1, 1'b1, '0, 1'b0);
        for (int i = 0; i < 20; i++) step("stream", 1'b1, 1'b0, '0, 1'b1);

        // Queue holding pcs 3..6, then a flush with a same-cycle handshake.
        step("jump3", 1'b1, 1'b1, 9'h003, 1'b0);
        for (int i = 0; i < 4; i++) step("load3", 1'b1, 1'b0, '0, 1'b0);
        step("flush", 1'b1, 1'b1, 9'h1F0, 1'b1);
        step("after_flush", 1'b1, 1'b0, '0, 1'b1);
        step("after_flush2", 1'b1, 1'b0, '0, 1'b1);

        // PC wrap across 2^PC_BITS.
        step("jump1fe", 1'b1, 1'b1, 9'h1FE, 1'b1);
        for (int i = 0; i < 6; i++) step("wrap", 1'b1, 1'b0, '0, 1'b1);

        // fetch_en low: drain only.
        for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'b0, '0, 1'b1);

        // Asynchronous reset mid-cycle with count=3.
        step("jump_r", 1'b1, 1'b1, '0, 1'b0);
        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b0, '0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        mq.delete();
        m_pc = '0;
        check_state("async_rst");
        @(negedge clock);
        reset = 1'b1;
        step("post_rst", 1'b1, 1'b0, '0, 1'b0);
        step("post_rst2", 1'b1, 1'b0, '0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                 PC_BITS'($urandom), ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
